// File: rtl/mbscore_if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, redirect input and decode-side output.
// The master modport is the fetch stage; the slave modport is its environment.
interface mbscore_if_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_inst;
  logic [DATA_WIDTH-1:0] out_pc;
  logic                  out_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid, out_inst, out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid, out_inst, out_pc,
    output out_ready
  );
endinterface

// File: rtl/mbscore_if_stage.sv
// MBScore instruction-fetch stage: owns the PC, keeps one memory read in flight and
// buffers returned words with their PCs in a small FIFO for the decode stage.
module mbscore_if_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input logic               clk,
  input logic               rst,
  mbscore_if_stage_if.master bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]         DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [PW-1:0]         PTR_ONE   = PW'(1);
  localparam logic [DATA_WIDTH-1:0] PC_STEP   = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~DATA_WIDTH'(3);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_reqPc;
  logic [DATA_WIDTH-1:0] r_bufInst [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_bufPc   [FIFO_DEPTH];
  logic [PW-1:0]         r_rdPtr;
  logic [PW-1:0]         r_wrPtr;
  logic [CW-1:0]         r_count;

  logic w_redirect;
  logic w_req;
  logic w_fire;
  logic w_push;
  logic w_pop;

  assign w_redirect = bus.redirect_valid;
  assign w_req      = !rst && (r_state == ST_RUN) && (r_count < DEPTH_C) && !w_redirect;
  assign w_fire     = w_req && bus.imem_gnt;
  assign w_push     = !w_redirect && (r_state == ST_WAIT) && bus.imem_rvalid;
  assign w_pop      = !w_redirect && (r_count != '0) && bus.out_ready;

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_pc;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_inst  = r_bufInst[r_rdPtr];
  assign bus.out_pc    = r_bufPc[r_rdPtr];

  // A redirect retires a pending response if it arrives now, otherwise marks it for discard.
  always_comb begin
    w_stateNext = r_state;
    if (w_redirect) begin
      case (r_state)
        ST_WAIT, ST_DROP: w_stateNext = bus.imem_rvalid ? ST_RUN : ST_DROP;
        default:          w_stateNext = ST_RUN;
      endcase
    end else begin
      case (r_state)
        ST_RUN:           if (w_fire)           w_stateNext = ST_WAIT;
        ST_WAIT, ST_DROP: if (bus.imem_rvalid)  w_stateNext = ST_RUN;
        default:          w_stateNext = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_stateNext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_reqPc <= '0;
    end else if (w_redirect) begin
      r_pc <= bus.redirect_pc & WORD_MASK;
    end else if (w_fire) begin
      r_reqPc <= r_pc;
      r_pc    <= r_pc + PC_STEP;
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_bufInst[i] <= '0;
        r_bufPc[i]   <= '0;
      end
    end else if (w_redirect) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_bufInst[r_wrPtr] <= bus.imem_rdata;
        r_bufPc[r_wrPtr]   <= r_reqPc;
        r_wrPtr            <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_mbscore_if_stage.sv
// Bench for mbscore_if_stage: directed scenarios plus a randomized phase, all checked
// against a queue-based model of the fetch stage; a second instance covers PC wrap.
module tb_mbscore_if_stage;
  localparam int          DW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  mbscore_if_stage_if #(.DATA_WIDTH(DW)) bus ();
  mbscore_if_stage_if #(.DATA_WIDTH(DW)) bus2 ();

  mbscore_if_stage #(.DATA_WIDTH(DW), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );
  mbscore_if_stage #(.DATA_WIDTH(DW), .RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2.master)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  bit          mKnown;
  bit          mOut;
  bit          mDrop;
  logic [31:0] mPc;
  logic [31:0] mReqAddr;
  logic [31:0] qPc[$];
  logic [31:0] qInst[$];

  bit          memBusy;
  int          memDelay;
  int          memLat;
  logic [31:0] memAddr;
  int          gntStall;
  bit          randGnt;

  logic [31:0] obsPc[$];
  logic [31:0] obsInst[$];

  bit          m2Busy;
  logic [31:0] m2Addr;
  int          c2;
  int          w2First;
  logic [31:0] w2Pc[$];
  logic [31:0] w2Inst[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, check against the model, then advance model and memories.
  task automatic applyStimulus(input bit doRst, input bit doRedir, input logic [31:0] rpc, input bit ready);
    bit          expReq;
    bit          mFire;
    bit          rv;
    bit          fire;
    logic [31:0] fireAddr;
    bit          f2;
    logic [31:0] a2;

    rst                = doRst;
    bus.redirect_valid = doRedir;
    bus.redirect_pc    = doRedir ? rpc : $urandom;
    bus.out_ready      = ready;
    rv                 = memBusy && (memDelay == 0);
    bus.imem_rvalid    = rv;
    bus.imem_rdata     = rv ? (memAddr ^ KEY) : $urandom;
    bus.imem_gnt       = (!memBusy || rv) && (gntStall == 0) && (!randGnt || ($urandom_range(0, 3) != 0));

    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = '0;
    bus2.out_ready      = 1'b1;
    bus2.imem_gnt       = 1'b1;
    bus2.imem_rvalid    = m2Busy;
    bus2.imem_rdata     = m2Addr ^ KEY;
    #1;

    expReq = !doRst && !mOut && (qPc.size() < DEPTH) && !doRedir;
    if (mKnown) begin
      checkOutput("imem_req", bus.imem_req, expReq);
      checkOutput("imem_addr", bus.imem_addr, mPc);
      checkOutput("out_valid", bus.out_valid, qPc.size() != 0);
      if (qPc.size() != 0) begin
        checkOutput("out_pc", bus.out_pc, qPc[0]);
        checkOutput("out_inst", bus.out_inst, qInst[0]);
      end
    end
    if (!doRst && bus.out_valid && ready) begin
      obsPc.push_back(bus.out_pc);
      obsInst.push_back(bus.out_inst);
    end
    if (!rst2 && bus2.out_valid) begin
      if (w2Pc.size() == 0) w2First = c2;
      w2Pc.push_back(bus2.out_pc);
      w2Inst.push_back(bus2.out_inst);
    end
    mFire    = expReq && bus.imem_gnt;
    fire     = bus.imem_req && bus.imem_gnt;
    fireAddr = bus.imem_addr;
    f2       = bus2.imem_req;
    a2       = bus2.imem_addr;

    @(posedge clk);

    if (doRst) begin
      mKnown = 1'b1;
      mPc    = 32'h0;
      mOut   = 1'b0;
      mDrop  = 1'b0;
      qPc.delete();
      qInst.delete();
    end else if (doRedir) begin
      qPc.delete();
      qInst.delete();
      mPc = rpc & 32'hFFFF_FFFC;
      if (mOut) begin
        if (rv) begin
          mOut  = 1'b0;
          mDrop = 1'b0;
        end else begin
          mDrop = 1'b1;
        end
      end
    end else begin
      if (qPc.size() != 0 && ready) begin
        void'(qPc.pop_front());
        void'(qInst.pop_front());
      end
      if (mOut && rv) begin
        if (!mDrop) begin
          qPc.push_back(mReqAddr);
          qInst.push_back(mReqAddr ^ KEY);
        end
        mOut  = 1'b0;
        mDrop = 1'b0;
      end
      if (mFire) begin
        mOut     = 1'b1;
        mReqAddr = mPc;
        mPc      = mPc + 32'd4;
      end
    end

    if (rv) memBusy = 1'b0;
    else if (memBusy && memDelay > 0) memDelay--;
    if (fire) begin
      memBusy  = 1'b1;
      memAddr  = fireAddr;
      memDelay = memLat;
    end
    if (gntStall > 0) gntStall--;

    m2Busy = f2;
    m2Addr = a2;
    c2     = rst2 ? 0 : c2 + 1;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rst2 = 1'b1;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready = 1'b0;
    mKnown = 1'b0; mOut = 1'b0; mDrop = 1'b0; mPc = '0; mReqAddr = '0;
    memBusy = 1'b0; memDelay = 0; memLat = 0; memAddr = '0; gntStall = 0; randGnt = 1'b0;
    m2Busy = 1'b0; m2Addr = '0; c2 = 0; w2First = -1;
    @(posedge clk);
    #1;

    $display("[TB] reset and zero-wait stream");
    repeat (3) applyStimulus(1, 0, 0, 1);
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_out_pc", bus.out_pc, 32'h0);
    checkOutput("rst_out_inst", bus.out_inst, 32'h0);
    checkOutput("rst_imem_addr", bus.imem_addr, 32'h0);
    checkOutput("rst_imem_req", bus.imem_req, 1'b0);
    obsPc.delete(); obsInst.delete();
    repeat (12) applyStimulus(0, 0, 0, 1);
    checkOutput("stream_count", obsPc.size(), 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stream_pc", obsPc[i], 32'(4 * i));
      checkOutput("stream_inst", obsInst[i], 32'(4 * i) ^ KEY);
    end

    $display("[TB] back-pressure fills the buffer");
    repeat (2) applyStimulus(1, 0, 0, 1);
    obsPc.delete(); obsInst.delete();
    repeat (10) applyStimulus(0, 0, 0, 0);
    checkOutput("full_imem_req", bus.imem_req, 1'b0);
    checkOutput("full_out_valid", bus.out_valid, 1'b1);
    checkOutput("full_head_pc", bus.out_pc, 32'h0);
    repeat (8) applyStimulus(0, 0, 0, 1);
    checkOutput("drain_count", obsPc.size(), 5);
    checkOutput("drain_pc0", obsPc[0], 32'h0);
    checkOutput("drain_pc1", obsPc[1], 32'h4);
    checkOutput("drain_pc2", obsPc[2], 32'h8);

    $display("[TB] redirect with a request in flight");
    repeat (2) applyStimulus(1, 0, 0, 1);
    memLat = 3;
    applyStimulus(0, 0, 0, 1);
    memLat = 0;
    applyStimulus(0, 0, 0, 1);
    obsPc.delete(); obsInst.delete();
    applyStimulus(0, 1, 32'h0000_0103, 1);
    checkOutput("redir_flushed", bus.out_valid, 1'b0);
    checkOutput("redir_pc", bus.imem_addr, 32'h0000_0100);
    repeat (12) applyStimulus(0, 0, 0, 1);
    checkOutput("redir_have_two", obsPc.size() >= 2, 1'b1);
    checkOutput("redir_first_pc", obsPc[0], 32'h0000_0100);
    checkOutput("redir_first_inst", obsInst[0], 32'h0000_0100 ^ KEY);
    checkOutput("redir_second_pc", obsPc[1], 32'h0000_0104);

    $display("[TB] grant stall");
    repeat (2) applyStimulus(1, 0, 0, 1);
    gntStall = 4;
    obsPc.delete(); obsInst.delete();
    repeat (4) applyStimulus(0, 0, 0, 1);
    checkOutput("stall_req", bus.imem_req, 1'b1);
    checkOutput("stall_addr", bus.imem_addr, 32'h0);
    repeat (6) applyStimulus(0, 0, 0, 1);
    checkOutput("stall_first_pc", obsPc[0], 32'h0);
    checkOutput("stall_count", obsPc.size(), 2);

    $display("[TB] reset while a request is in flight");
    repeat (2) applyStimulus(1, 0, 0, 1);
    memLat = 2;
    applyStimulus(0, 0, 0, 1);
    memLat = 0;
    applyStimulus(1, 0, 0, 1);
    checkOutput("midrst_out_valid", bus.out_valid, 1'b0);
    checkOutput("midrst_out_pc", bus.out_pc, 32'h0);
    checkOutput("midrst_out_inst", bus.out_inst, 32'h0);
    checkOutput("midrst_addr", bus.imem_addr, 32'h0);
    obsPc.delete(); obsInst.delete();
    repeat (10) applyStimulus(0, 0, 0, 1);
    checkOutput("midrst_count", obsPc.size(), 4);
    checkOutput("midrst_pc0", obsPc[0], 32'h0);
    checkOutput("midrst_inst0", obsInst[0], KEY);
    checkOutput("midrst_pc1", obsPc[1], 32'h4);

    $display("[TB] randomized traffic");
    randGnt = 1'b1;
    for (int i = 0; i < 400; i++) begin
      memLat = $urandom_range(0, 2);
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, $urandom,
                    $urandom_range(0, 3) != 0);
    end
    randGnt = 1'b0;
    memLat = 0;
    repeat (6) applyStimulus(0, 0, 0, 1);

    $display("[TB] PC wrap from RESET_PC");
    repeat (2) applyStimulus(0, 0, 0, 1);
    rst2 = 1'b0;
    w2Pc.delete(); w2Inst.delete(); w2First = -1;
    repeat (8) applyStimulus(0, 0, 0, 1);
    checkOutput("wrap_first_valid", w2First, 2);
    checkOutput("wrap_count", w2Pc.size(), 3);
    checkOutput("wrap_pc0", w2Pc[0], 32'hFFFF_FFF8);
    checkOutput("wrap_pc1", w2Pc[1], 32'hFFFF_FFFC);
    checkOutput("wrap_pc2", w2Pc[2], 32'h0000_0000);
    checkOutput("wrap_inst0", w2Inst[0], 32'hFFFF_FFF8 ^ KEY);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mbscore_if_stage.md
# mbscore_if_stage

Instruction-fetch stage of the MBScore pipeline. It owns the program counter and issues word reads to instruction memory over a request/grant/response handshake. Returned words are buffered, with their PCs, in a small FIFO and presented to the control/decode stage under a valid/ready handshake. Jump and branch redirects from the control stage flush the buffer, drop any in-flight response and restart fetch at the new PC.

## Interface
- DATA_WIDTH, 32, instruction and address width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- FIFO_DEPTH, 2, fetch buffer entries (power of two, ≥2)

- clk  input  1  rising-edge clock
- rst  input  1  reset: **synchronous, active-high**
- imem_req  output  1  read request
- imem_addr  output  DATA_WIDTH  read address; always equals the current pc
- imem_gnt  input  1  request accepted this cycle
- imem_rvalid  input  1  read data valid
- imem_rdata  input  DATA_WIDTH  instruction word
- redirect_valid  input  1  jump/branch taken
- redirect_pc  input  DATA_WIDTH  new fetch address; bits [1:0] are ignored and forced to 00
- out_valid  output  1  out_inst and out_pc are valid
- out_inst  output  DATA_WIDTH  instruction at FIFO head
- out_pc  output  DATA_WIDTH  address of out_inst
- out_ready  input  1  decode accepts the head entry

## Operation
- Registers:
  - pc
  - req_pc: address of the outstanding request
  - FIFO storage, read pointer, write pointer, count
  - fsm state
- FSM states: RUN (no request outstanding), WAIT (one request outstanding), DROP (outstanding response is to be discarded).
- Issue: imem_req = (state==RUN) && (count < FIFO_DEPTH) && !redirect_valid.
- On imem_req && imem_gnt:
  - req_pc <= pc
  - pc <= pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0
  - state <= WAIT
- Response handling:
  - WAIT with imem_rvalid: push {req_pc, imem_rdata}; state <= RUN.
  - DROP with imem_rvalid: discard the data; state <= RUN.
  - RUN with imem_rvalid (stray response, e.g. after reset): ignore it.
- Only one request is ever outstanding. No new request is issued in the same cycle a response arrives.
- Output side:
  - out_valid = (count != 0).
  - out_inst and out_pc come directly from the head register.
  - A pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - A push never occurs with count == FIFO_DEPTH, because issue requires free space.
- Redirect (redirect_valid=1) has priority over everything else in that cycle:
  - FIFO is flushed: count <= 0 and pointers reset; a pop in the same cycle is void.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - imem_req is forced to 0.
  - WAIT without rvalid → DROP.
  - WAIT with rvalid → data discarded, state RUN.
  - DROP → stays DROP unless rvalid is present, in which case → RUN.
  - RUN → stays RUN.
  - Back-to-back redirects: the last one wins.
- Control must drive redirect_pc as the full target address. For J-type it is {out_pc+4}[31:28] concatenated with jump_addr and 2'b00.

## Timing
- Reset values:
  - pc = RESET_PC
  - req_pc = 0
  - state = RUN
  - count = 0, pointers = 0
  - out_valid = 0, out_inst = 0, out_pc = 0 (head register cleared)
  - imem_req is 0 during reset.
- Reset mid-operation aborts any outstanding request. Memory must be reset together with this block; a late rvalid after reset arrives in RUN and is ignored.
- Response latency:
  - imem_rvalid in cycle N → out_valid=1 in cycle N+1.
  - With zero-wait memory (gnt same cycle, rvalid next cycle): first rst-low cycle C issues; out_valid rises at C+2.
  - Steady state is one instruction every 2 cycles.
- The redirect takes effect at the next edge. With zero-wait memory:
  - the first request to the new PC issues at R+1;
  - its instruction appears at R+3.
- With out_ready held low, fetch stops after FIFO_DEPTH entries. Issue resumes in the cycle after a pop makes count < FIFO_DEPTH.

## Test plan
- Reset, then zero-wait memory returning imem_rdata=addr^32'hA5A5_0000, out_ready=1 → out_pc sequence 0,4,8,… with matching inst; first out_valid 2 cycles after rst falls.
- out_ready=0 for 10 cycles → exactly 2 entries buffered (pc 0, 4); imem_req=0 while full; raising out_ready drains 0,4, then 8 is fetched with no loss or duplication.
- redirect_valid with redirect_pc=32'h0000_0103 while a request is outstanding (rvalid delayed 3 cycles) → the stale word is never output; the next out_pc is 32'h0000_0100; FIFO is emptied in the redirect cycle.
- RESET_PC=32'hFFFF_FFF8 → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- imem_gnt held low for 4 cycles → imem_req and imem_addr stay stable; pc does not advance until gnt.
- rst asserted in WAIT with rvalid 2 cycles later → outputs return to reset values, the stray rvalid produces no output, and fetch restarts at RESET_PC.
